// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM shadow-register update path: counter modes,
// controller state encoding and field widths.
package pwm_pkg;

  localparam logic MODE_EDGE   = 1'b0;
  localparam logic MODE_CENTER = 1'b1;

  localparam int unsigned DeadtimeWidth = 16;
  localparam int unsigned RepWidth      = 8;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StPend = 2'd2
  } pwm_state_e;

  // Edge-aligned counters wrap at the active period; center-aligned ones turn at zero.
  function automatic logic is_boundary(input logic mode,
                                       input logic tick,
                                       input logic cnt_zero,
                                       input logic cnt_at_period);
    logic hit;
    hit = 1'b0;
    unique case (mode)
      MODE_EDGE:   hit = cnt_at_period;
      MODE_CENTER: hit = cnt_zero;
      default:     hit = 1'b0;
    endcase
    return tick & hit;
  endfunction

endpackage

// File: rtl/pwm_upd_detect.sv
// Period-boundary detection and repetition down-counter; raises a one-cycle
// apply request on every (rep+1)-th boundary or on a forced software update.
module pwm_upd_detect
  import pwm_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                active_i,
  input  logic                mode_i,
  input  logic                tick_i,
  input  logic [WIDTH-1:0]    cnt_i,
  input  logic [WIDTH-1:0]    act_period_i,
  input  logic [RepWidth-1:0] rep_i,
  input  logic                force_upd_i,
  output logic                apply_req_o
);

  logic [RepWidth-1:0] rep_cnt_d, rep_cnt_q;
  logic                bnd;
  logic                cnt_zero;
  logic                cnt_at_period;

  assign cnt_zero      = (cnt_i == '0);
  assign cnt_at_period = (cnt_i == act_period_i);
  assign bnd           = is_boundary(mode_i, tick_i, cnt_zero, cnt_at_period);

  // While inactive the counter tracks rep so the first period after enable
  // starts with a fresh repetition count.
  always_comb begin
    rep_cnt_d   = rep_cnt_q;
    apply_req_o = 1'b0;
    if (!active_i) begin
      rep_cnt_d = rep_i;
    end else if (force_upd_i) begin
      apply_req_o = 1'b1;
      rep_cnt_d   = rep_i;
    end else if (bnd) begin
      if (rep_cnt_q == '0) begin
        apply_req_o = 1'b1;
        rep_cnt_d   = rep_i;
      end else begin
        rep_cnt_d = rep_cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rep_cnt_q <= '0;
    end else begin
      rep_cnt_q <= rep_cnt_d;
    end
  end

endmodule

// File: rtl/pwm_shadow_sync.sv
// Shadow-register update unit: holds preload values and copies them to the
// active set only at period boundaries, after repetitions, or on force.
module pwm_shadow_sync
  import pwm_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     en_i,
  input  logic                     mode_i,
  input  logic                     tick_i,
  input  logic [WIDTH-1:0]         cnt_i,
  input  logic                     arpe_i,
  input  logic [RepWidth-1:0]      rep_i,
  input  logic                     reg_wr_i,
  input  logic                     force_upd_i,
  input  logic [WIDTH-1:0]         pre_period_i,
  input  logic [WIDTH-1:0]         pre_ccr_on_i,
  input  logic [WIDTH-1:0]         pre_ccr_i,
  input  logic [DeadtimeWidth-1:0] pre_deadtime_i,
  output logic [WIDTH-1:0]         act_period_o,
  output logic [WIDTH-1:0]         act_ccr_on_o,
  output logic [WIDTH-1:0]         act_ccr_o,
  output logic [DeadtimeWidth-1:0] act_deadtime_o,
  output logic                     upd_evt_o,
  output logic                     upd_pending_o,
  output logic                     err_o
);

  pwm_state_e state_d, state_q;

  logic [WIDTH-1:0]         act_period_d, act_period_q;
  logic [WIDTH-1:0]         act_ccr_on_d, act_ccr_on_q;
  logic [WIDTH-1:0]         act_ccr_d, act_ccr_q;
  logic [DeadtimeWidth-1:0] act_deadtime_d, act_deadtime_q;
  logic                     upd_evt_d, upd_evt_q;
  logic                     err_d, err_q;

  logic active;
  logic apply_req;
  logic reject;
  logic accept;
  logic copy_all;

  assign active = en_i && (state_q != StIdle);

  pwm_upd_detect #(
    .WIDTH (WIDTH)
  ) u_upd_detect (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .active_i     (active),
    .mode_i       (mode_i),
    .tick_i       (tick_i),
    .cnt_i        (cnt_i),
    .act_period_i (act_period_q),
    .rep_i        (rep_i),
    .force_upd_i  (force_upd_i),
    .apply_req_o  (apply_req)
  );

  // A zero period would stall the counter, so such an update is refused.
  assign reject   = active && apply_req && (pre_period_i == '0);
  assign accept   = active && apply_req && !reject;
  assign copy_all = !active || (accept && (state_q == StPend));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (en_i) state_d = StRun;
      end
      StRun: begin
        if (reg_wr_i) state_d = StPend;
      end
      StPend: begin
        // A write landing on the apply cycle keeps the new values pending.
        if (!reg_wr_i && accept) state_d = StRun;
      end
      default: state_d = StIdle;
    endcase
    if (!en_i) state_d = StIdle;
  end

  always_comb begin
    act_period_d   = act_period_q;
    act_ccr_on_d   = act_ccr_on_q;
    act_ccr_d      = act_ccr_q;
    act_deadtime_d = act_deadtime_q;
    upd_evt_d      = accept;
    err_d          = err_q;

    if (copy_all) begin
      act_period_d   = pre_period_i;
      act_ccr_on_d   = pre_ccr_on_i;
      act_ccr_d      = pre_ccr_i;
      act_deadtime_d = pre_deadtime_i;
    end
    // Unbuffered period: only the period field bypasses the shadow stage.
    if (active && !arpe_i) begin
      act_period_d = pre_period_i;
    end

    if (reject) begin
      err_d = 1'b1;
    end else if (reg_wr_i) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= StIdle;
      act_period_q   <= '0;
      act_ccr_on_q   <= '0;
      act_ccr_q      <= '0;
      act_deadtime_q <= '0;
      upd_evt_q      <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      act_period_q   <= act_period_d;
      act_ccr_on_q   <= act_ccr_on_d;
      act_ccr_q      <= act_ccr_d;
      act_deadtime_q <= act_deadtime_d;
      upd_evt_q      <= upd_evt_d;
      err_q          <= err_d;
    end
  end

  assign act_period_o   = act_period_q;
  assign act_ccr_on_o   = act_ccr_on_q;
  assign act_ccr_o      = act_ccr_q;
  assign act_deadtime_o = act_deadtime_q;
  assign upd_evt_o      = upd_evt_q;
  assign upd_pending_o  = (state_q == StPend);
  assign err_o          = err_q;

endmodule

// File: doc/pwm_shadow_sync.md
# pwm_shadow_sync

Shadow-register update unit between the PWM register block and the counter/comparator/deadtime datapath. Holds the software-written preload values (period, CCR_ON, CCR, deadtime) and transfers them to the active copies only at a period boundary, after a programmable number of repetitions, or on a forced software update. This prevents glitched or torn PWM periods when I2C writes land mid-period.

## Interface
- WIDTH, 32, counter/compare width
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  PWM enable from register block
- mode  in  1  counter mode: 0 edge-aligned, 1 center-aligned
- tick  in  1  prescaler tick, one-cycle pulse
- cnt  in  WIDTH  current counter value
- arpe  in  1  period preload enable; 0 = period written through without buffering
- rep  in  8  repetition count; update applied every rep+1 boundaries
- reg_wr  in  1  one-cycle strobe: a preload register was written (pre_* valid from next cycle)
- force_upd  in  1  one-cycle software update request
- pre_period, pre_ccr_on, pre_ccr  in  WIDTH  preload values
- pre_deadtime  in  16  preload deadtime
- act_period, act_ccr_on, act_ccr  out  WIDTH  active values to counter/comparator
- act_deadtime  out  16  active deadtime
- upd_evt  out  1  one-cycle pulse, active values changed this cycle
- upd_pending  out  1  preload differs from active (write not yet applied)
- err  out  1  sticky: an update was rejected because pre_period was 0

## Operation
- States: IDLE (en=0), RUN (en=1, nothing pending), PEND (en=1, write pending).
- IDLE: each cycle act_* <= pre_*; rep_cnt <= rep; upd_pending=0; upd_evt not asserted. This gives fresh values at enable.
- IDLE->RUN when en rises. RUN->PEND on reg_wr. PEND->RUN on an applied update. Any state->IDLE when en=0.
- Boundary (bnd): mode=0: tick && cnt==act_period; mode=1: tick && cnt==0.
- On bnd: if rep_cnt==0, apply the update and reload rep_cnt<=rep; else rep_cnt<=rep_cnt-1.
- Apply in RUN: no value change, but upd_evt still pulses.
- Apply in PEND: all act_* <= pre_*; go to RUN.
- force_upd (en=1): apply immediately regardless of bnd/rep_cnt; rep_cnt<=rep.
- arpe=0: act_period <= pre_period every cycle in RUN/PEND. The CCR and deadtime fields stay buffered.
- Reject: an apply with pre_period==0 leaves all act_* unchanged, sets err, suppresses upd_evt, and keeps the state in PEND. err clears only on reg_wr or rst_n.
- Simultaneous reg_wr and apply in the same cycle: the copy uses the pre_* values present that cycle; the state stays/returns to PEND (the new write is still pending).
- Simultaneous force_upd and bnd: treated as a single apply, one upd_evt pulse.

## Timing
- Reset: act_* = 0, rep_cnt = 0, upd_evt = 0, upd_pending = 0, err = 0, state IDLE.
- Latency: bnd or force_upd sampled at cycle N; act_* and upd_evt change at N+1.
- IDLE and arpe=0 pass-through: 1-cycle registered latency.
- upd_pending is a registered state decode: 1 in PEND.
- Reset mid-operation: asynchronous clear to the reset values; no partial copy.
- rep_cnt width 8. rep changes take effect at the next reload only.

## Structure
- The shared package pwm_pkg holds:
  - MODE_EDGE=1'b0 and MODE_CENTER=1'b1;
  - the state encoding (IDLE/RUN/PEND);
  - the deadtime width constant 16.
- Sub-module pwm_upd_detect: boundary detection plus the repetition down-counter. Outputs a one-cycle apply_req.
- Top level: state machine, shadow registers, reject logic.

## Test plan
- Reset, then en=0 with pre_period=99: act_period=99 one cycle later; upd_evt never asserted.
- en=1, mode=0, period 9, rep=0; write pre_ccr=5 at cnt=3: act_ccr unchanged until the cycle after tick with cnt==9, then 5; exactly one upd_evt; upd_pending 1→0.
- rep=2, pending write: the apply happens on the third boundary only. force_upd mid-period applies next cycle and reloads rep_cnt to 2.
- mode=1, period 8: update applied only after the tick at cnt==0, not at cnt==8.
- pre_period=0 written, boundary reached: act_* hold, err=1, upd_pending stays 1. Writing pre_period=20: err clears and the next boundary applies 20.
- reg_wr coincident with a boundary: act_* get the old preload; upd_pending stays 1; the new values apply at the following boundary. Assert rst_n low mid-period: all outputs 0 asynchronously.
